ovr_i_shtdwn_gen: RTL and testbench

Generates the motor-driver overcurrent shutdown request (OVR_I_shtdwn) consumed by mtr_drv, which forces pwr_up low and zeroes both wheel drives. The block takes the raw asynchronous OVR_I_lft/OVR_I_rght comparator pins and ignores them during a blanking interval after each PWM period start, masking switching transients. A fault is recorded for each PWM period containing a qualified overcurrent. Shutdown latches after FAULT_LIMIT consecutive faulted periods.

---
 rtl/ovr_i_shtdwn_gen_pkg.sv | 10 +
 rtl/ovr_i_shtdwn_gen_if.sv | 10 +
 rtl/ovr_i_shtdwn_gen_synch.sv | 13 +
 rtl/ovr_i_shtdwn_gen.sv | 60 ++++++
 tb/tb_ovr_i_shtdwn_gen.sv | 133 +++++++++++++
 5 files changed

// File: rtl/ovr_i_shtdwn_gen_pkg.sv
// segway_ovr_pkg: shared state encoding, default parameters and helpers for the overcurrent shutdown block
package segway_ovr_pkg;
  typedef enum logic [1:0] {BLANK = 2'd0, WINDOW = 2'd1, TRIPPED = 2'd2} ovr_state_t;
  localparam int OVR_PERIOD = 2048;
  localparam int OVR_BLANK_CYC = 128;
  localparam int OVR_FAULT_LIMIT = 3;
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction
endpackage

// File: rtl/ovr_i_shtdwn_gen_if.sv
// ovr_i_shtdwn_gen_if: PWM_synch/OVR_I pins in, OVR_I_shtdwn/flt_cnt out; master drives stimulus, slave is the block
interface ovr_i_shtdwn_gen_if;
  logic       PWM_synch;
  logic       OVR_I_lft;
  logic       OVR_I_rght;
  logic       OVR_I_shtdwn;
  logic [3:0] flt_cnt;
  modport master(output PWM_synch, OVR_I_lft, OVR_I_rght, input OVR_I_shtdwn, flt_cnt);
  modport slave(input PWM_synch, OVR_I_lft, OVR_I_rght, output OVR_I_shtdwn, flt_cnt);
endinterface

// File: rtl/ovr_i_shtdwn_gen_synch.sv
// ovr_i_synch: 2-flop synchroniser; clk, rst_n (async low), d_i raw pin, q_o synchronised level
module ovr_i_synch (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s2_q, s1_q} <= 2'b00;
    else {s2_q, s1_q} <= {s1_q, d_i};
  assign q_o = s2_q;
endmodule

// File: rtl/ovr_i_shtdwn_gen.sv
// ovr_i_shtdwn_gen: blanked overcurrent fault counter with sticky shutdown; clk, rst_n (async low), ovr_if slave (PWM_synch, OVR_I_lft/rght in; OVR_I_shtdwn, flt_cnt out)
module ovr_i_shtdwn_gen
  import segway_ovr_pkg::*;
#(
  parameter int PERIOD = OVR_PERIOD,
  parameter int BLANK_CYC = OVR_BLANK_CYC,
  parameter int FAULT_LIMIT = OVR_FAULT_LIMIT
) (
  input logic clk,
  input logic rst_n,
  ovr_i_shtdwn_gen_if.slave ovr_if
);
  localparam int CW = $clog2(PERIOD);
  localparam logic [1:0] ST_BLANK = BLANK;
  localparam logic [1:0] ST_WINDOW = WINDOW;
  localparam logic [1:0] ST_TRIPPED = TRIPPED;
  logic lft_s, rght_s, ovr_any, run, close, qual, hit, trip;
  logic [CW-1:0] blk_cnt_q, blk_cnt_d;
  logic [1:0] state_q, state_d;
  logic prd_flt_q, prd_flt_d, shtdwn_q, shtdwn_d;
  logic [3:0] flt_cnt_q, flt_cnt_d, cnt_nxt;
  ovr_i_synch u_sync_lft (.clk(clk), .rst_n(rst_n), .d_i(ovr_if.OVR_I_lft), .q_o(lft_s));
  ovr_i_synch u_sync_rght (.clk(clk), .rst_n(rst_n), .d_i(ovr_if.OVR_I_rght), .q_o(rght_s));
  assign ovr_any = lft_s | rght_s;
  always_comb begin
    run = state_q != ST_TRIPPED;
    close = run & ovr_if.PWM_synch;
    qual = (state_q == ST_WINDOW) & ovr_any;
    hit = prd_flt_q | qual;
    cnt_nxt = hit ? sat_inc(flt_cnt_q) : 4'd0;
    trip = close & (cnt_nxt >= 4'(FAULT_LIMIT));
    flt_cnt_d = close ? cnt_nxt : flt_cnt_q;
    prd_flt_d = close ? 1'b0 : prd_flt_q | qual;
    blk_cnt_d = !run ? blk_cnt_q
              : ovr_if.PWM_synch ? '0
              : (state_q == ST_BLANK && blk_cnt_q != CW'(BLANK_CYC)) ? blk_cnt_q + 1'b1
              : blk_cnt_q;
    state_d = trip ? ST_TRIPPED
            : close ? ST_BLANK
            : (state_q == ST_BLANK && blk_cnt_q == CW'(BLANK_CYC - 1)) ? ST_WINDOW
            : state_q;
    shtdwn_d = shtdwn_q | trip;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      blk_cnt_q <= '0;
      state_q <= ST_BLANK;
      prd_flt_q <= 1'b0;
      flt_cnt_q <= 4'd0;
      shtdwn_q <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      state_q <= state_d;
      prd_flt_q <= prd_flt_d;
      flt_cnt_q <= flt_cnt_d;
      shtdwn_q <= shtdwn_d;
    end
  assign ovr_if.OVR_I_shtdwn = shtdwn_q;
  assign ovr_if.flt_cnt = flt_cnt_q;
endmodule

// File: tb/tb_ovr_i_shtdwn_gen.sv
// tb_ovr_i_shtdwn_gen: scoreboard bench for blanking, fault counting, trip, stickiness and async reset
module tb_ovr_i_shtdwn_gen;
  import segway_ovr_pkg::*;
  localparam int PRD = 1024;
  localparam int BLK = 128;
  localparam int LIM = 3;
  typedef struct {int cnt; bit trip;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vecs = 0;
  int errs = 0;
  int m_cnt = 0;
  bit m_trip = 1'b0;
  exp_t sb[$];
  always #5 clk = ~clk;
  ovr_i_shtdwn_gen_if bus();
  ovr_i_shtdwn_gen #(.PERIOD(PRD), .BLANK_CYC(BLK), .FAULT_LIMIT(LIM)) dut (.clk(clk), .rst_n(rst_n), .ovr_if(bus));
  // A pin high for the cycle sampled at offset t reaches the FSM at offset t+2;
  // the window samples offsets BLK+1..PRD (PRD being the closing synch edge).
  function automatic bit counted(int s, int e);
    return s <= e && e >= BLK - 1 && s <= PRD - 2;
  endfunction
  task automatic period(string nm, int ls, int le, int rs, int re);
    exp_t x, g;
    int pc;
    bit pt, hit;
    pc = m_cnt;
    pt = m_trip;
    hit = counted(ls, le) | counted(rs, re);
    if (!m_trip) begin
      m_cnt = hit ? (m_cnt == 15 ? 15 : m_cnt + 1) : 0;
      m_trip = m_cnt >= LIM;
    end
    x.cnt = m_cnt;
    x.trip = m_trip;
    sb.push_back(x);
    for (int t = 1; t <= PRD; t++) begin
      bus.OVR_I_lft = (t >= ls && t <= le);
      bus.OVR_I_rght = (t >= rs && t <= re);
      bus.PWM_synch = (t == PRD);
      @(posedge clk);
      #1;
      if (t < PRD) begin
        vecs++;
        if (bus.flt_cnt !== 4'(pc) || bus.OVR_I_shtdwn !== pt) begin
          errs++;
          $display("FAIL %s mid t=%0d: got cnt=%0d shtdwn=%b, want cnt=%0d shtdwn=%b", nm, t, bus.flt_cnt, bus.OVR_I_shtdwn, pc, pt);
        end
      end
    end
    bus.PWM_synch = 1'b0;
    bus.OVR_I_lft = 1'b0;
    bus.OVR_I_rght = 1'b0;
    g = sb.pop_front();
    vecs++;
    if (bus.flt_cnt !== 4'(g.cnt) || bus.OVR_I_shtdwn !== g.trip) begin
      errs++;
      $display("FAIL %s close: got cnt=%0d shtdwn=%b, want cnt=%0d shtdwn=%b", nm, bus.flt_cnt, bus.OVR_I_shtdwn, g.cnt, g.trip);
    end
  endtask
  task automatic do_reset(string nm);
    bus.PWM_synch = 1'b0;
    bus.OVR_I_lft = 1'b0;
    bus.OVR_I_rght = 1'b0;
    rst_n = 1'b0;
    m_cnt = 0;
    m_trip = 1'b0;
    #2;
    vecs++;
    if (bus.flt_cnt !== 4'd0 || bus.OVR_I_shtdwn !== 1'b0) begin
      errs++;
      $display("FAIL %s async: got cnt=%0d shtdwn=%b, want cnt=0 shtdwn=0", nm, bus.flt_cnt, bus.OVR_I_shtdwn);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    #1;
    do_reset("reset");
  endtask
  task automatic test_blanking();
    for (int p = 0; p < 10; p++) period("blanking", 10, 100, 1, 0);
  endtask
  task automatic test_trip();
    for (int p = 0; p < 3; p++) period("trip", 1, 0, 500, 520);
  endtask
  task automatic test_sticky_reset();
    for (int p = 0; p < 5; p++) period("sticky", 1, 0, 1, 0);
    bus.OVR_I_lft = 1'b1;
    repeat (300) @(posedge clk);
    #3;
    do_reset("reset_mid");
    period("post_rst_blank", 10, 100, 1, 0);
    period("post_rst_fault", 400, 410, 1, 0);
    period("post_rst_clean", 1, 0, 1, 0);
  endtask
  task automatic test_consec_clear();
    period("consec1", 600, 620, 1, 0);
    period("consec2", 1, 0, 700, 705);
    period("consec3", 1, 0, 1, 0);
    period("consec4", 300, 300, 1, 0);
    period("consec5", 1, 0, 1, 0);
  endtask
  task automatic test_window_edge();
    period("edge_blk_m2", BLK - 2, BLK - 2, 1, 0);
    period("edge_blk_m1", BLK - 1, BLK - 1, 1, 0);
    period("edge_clean1", 1, 0, 1, 0);
    period("edge_blk_p2", 1, 0, BLK + 2, BLK + 2);
    period("edge_clean2", 1, 0, 1, 0);
    period("edge_at_synch", PRD - 2, PRD - 2, 1, 0);
    period("edge_past_synch", PRD - 1, PRD - 1, 1, 0);
  endtask
  task automatic test_both_pins();
    period("both1", 300, 400, 350, 450);
    period("both2", 200, 900, 200, 900);
    period("both_clean", 1, 0, 1, 0);
  endtask
  initial begin
    bus.PWM_synch = 1'b0;
    bus.OVR_I_lft = 1'b0;
    bus.OVR_I_rght = 1'b0;
    test_reset();
    test_blanking();
    test_trip();
    test_sticky_reset();
    test_consec_clear();
    test_window_edge();
    test_both_pins();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
